// File: rtl/rob_multi_commit.sv
`default_nettype none
// ============================================================================
// Module   : rob_multi_commit
// Purpose  : Reorder buffer with N writeback ports, operand bypass and up to
//            two in-order commits per cycle; raises a registered flush with
//            redirect PC on a misprediction. Occupancy is kept as an explicit
//            count, so every slot is usable.
// Revision : 1.0 - initial release
// ============================================================================
module rob_multi_commit #(
  parameter int ROB_WIDTH    = 4,
  parameter int WB_PORTS     = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             issue_valid,
  input  logic [4:0]                       issue_rd,
  input  logic [31:0]                      issue_pc,
  input  logic                             issue_is_br,
  input  logic                             issue_is_jalr,
  input  logic                             issue_is_store,
  input  logic                             issue_pred_taken,
  output logic                             rob_full,
  output logic                             rob_empty,
  output logic [ROB_WIDTH-1:0]             rob_new_idx,
  input  logic [WB_PORTS-1:0]              wb_valid,
  input  logic [WB_PORTS*ROB_WIDTH-1:0]    wb_idx,
  input  logic [WB_PORTS*32-1:0]           wb_val,
  input  logic [WB_PORTS-1:0]              wb_taken,
  input  logic [WB_PORTS*32-1:0]           wb_target,
  input  logic [ROB_WIDTH-1:0]             q1_idx,
  input  logic [ROB_WIDTH-1:0]             q2_idx,
  output logic                             q1_ready,
  output logic                             q2_ready,
  output logic [31:0]                      q1_val,
  output logic [31:0]                      q2_val,
  output logic [COMMIT_WIDTH-1:0]          cm_valid,
  output logic [COMMIT_WIDTH*5-1:0]        cm_rd,
  output logic [COMMIT_WIDTH*32-1:0]       cm_val,
  output logic [COMMIT_WIDTH*ROB_WIDTH-1:0] cm_idx,
  output logic                             st_commit,
  output logic [ROB_WIDTH-1:0]             st_commit_idx,
  output logic                             bp_valid,
  output logic [31:0]                      bp_pc,
  output logic                             bp_taken,
  output logic                             flush_out,
  output logic [31:0]                      flush_pc
);

  localparam int                  ROB_SIZE = 2**ROB_WIDTH;
  localparam logic [ROB_WIDTH:0]  CNT_FULL = (ROB_WIDTH+1)'(ROB_SIZE);
  localparam logic [ROB_WIDTH:0]  CNT_TWO  = (ROB_WIDTH+1)'(2);
  localparam logic [ROB_WIDTH-1:0] IDX_ONE = ROB_WIDTH'(1);

  // Control state
  logic [ROB_WIDTH-1:0] head_q, tail_q, head_d, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;
  logic [ROB_SIZE-1:0]  ready_q;

  // Entry payload
  logic [4:0]           rd_q     [ROB_SIZE];
  logic [31:0]          pc_q     [ROB_SIZE];
  logic [31:0]          val_q    [ROB_SIZE];
  logic [31:0]          target_q [ROB_SIZE];
  logic [ROB_SIZE-1:0]  br_q, jalr_q, st_q, pred_q, taken_q;

  // Registered output pulses
  logic [COMMIT_WIDTH-1:0]           cm_valid_q;
  logic [COMMIT_WIDTH*5-1:0]         cm_rd_q;
  logic [COMMIT_WIDTH*32-1:0]        cm_val_q;
  logic [COMMIT_WIDTH*ROB_WIDTH-1:0] cm_idx_q;
  logic                              st_commit_q, bp_valid_q, bp_taken_q, flush_q;
  logic [ROB_WIDTH-1:0]              st_commit_idx_q;
  logic [31:0]                       bp_pc_q, flush_pc_q;

  // Per-cycle decisions
  logic                 issue_w, commit0_w, commit1_w, mispred_w, special0_w, special1_w;
  logic [ROB_WIDTH-1:0] head1_w;
  logic [ROB_WIDTH:0]   ncommit_w;
  logic [1:0]           fire_w;
  logic [ROB_WIDTH-1:0] slot_idx_w [2];

  assign rob_full    = (count_q == CNT_FULL);
  assign rob_empty   = (count_q == '0);
  assign rob_new_idx = tail_q;

  assign issue_w    = issue_valid && !rob_full && !flush_q;
  assign head1_w    = head_q + IDX_ONE;
  assign special0_w = br_q[head_q] | jalr_q[head_q] | st_q[head_q];
  assign special1_w = br_q[head1_w] | jalr_q[head1_w] | st_q[head1_w];
  assign commit0_w  = !rob_empty && ready_q[head_q] && !flush_q;
  // jalr always redirects; a branch redirects only when the guess was wrong
  assign mispred_w  = commit0_w &&
                      (jalr_q[head_q] || (br_q[head_q] && (pred_q[head_q] != taken_q[head_q])));
  assign commit1_w  = (COMMIT_WIDTH == 2) && (count_q >= CNT_TWO) && ready_q[head1_w] &&
                      commit0_w && !special0_w && !special1_w && !mispred_w;

  assign ncommit_w     = (ROB_WIDTH+1)'(commit0_w) + (ROB_WIDTH+1)'(commit1_w);
  assign head_d        = head_q + ROB_WIDTH'(ncommit_w);
  assign tail_d        = issue_w ? (tail_q + IDX_ONE) : tail_q;
  assign count_d       = count_q + (ROB_WIDTH+1)'(issue_w) - ncommit_w;
  assign fire_w        = {commit1_w, commit0_w};
  assign slot_idx_w[0] = head_q;
  assign slot_idx_w[1] = head1_w;

  assign cm_valid      = cm_valid_q;
  assign cm_rd         = cm_rd_q;
  assign cm_val        = cm_val_q;
  assign cm_idx        = cm_idx_q;
  assign st_commit     = st_commit_q;
  assign st_commit_idx = st_commit_idx_q;
  assign bp_valid      = bp_valid_q;
  assign bp_pc         = bp_pc_q;
  assign bp_taken      = bp_taken_q;
  assign flush_out     = flush_q;
  assign flush_pc      = flush_pc_q;

  // Operand lookup with same-cycle writeback bypass; the highest matching port wins
  always_comb begin
    q1_ready = ready_q[q1_idx];
    q1_val   = val_q[q1_idx];
    q2_ready = ready_q[q2_idx];
    q2_val   = val_q[q2_idx];
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_valid[k] && (wb_idx[k*ROB_WIDTH +: ROB_WIDTH] == q1_idx)) begin
        q1_ready = 1'b1;
        q1_val   = wb_val[k*32 +: 32];
      end
      if (wb_valid[k] && (wb_idx[k*ROB_WIDTH +: ROB_WIDTH] == q2_idx)) begin
        q2_ready = 1'b1;
        q2_val   = wb_val[k*32 +: 32];
      end
    end
  end

  // Pointers, ready bits and the registered retire/flush pulses
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      ready_q         <= '0;
      cm_valid_q      <= '0;
      cm_rd_q         <= '0;
      cm_val_q        <= '0;
      cm_idx_q        <= '0;
      st_commit_q     <= 1'b0;
      st_commit_idx_q <= '0;
      bp_valid_q      <= 1'b0;
      bp_pc_q         <= '0;
      bp_taken_q      <= 1'b0;
      flush_q         <= 1'b0;
      flush_pc_q      <= '0;
    end else if (rdy_in) begin
      if (flush_q) begin
        head_q          <= '0;
        tail_q          <= '0;
        count_q         <= '0;
        ready_q         <= '0;
        cm_valid_q      <= '0;
        cm_rd_q         <= '0;
        cm_val_q        <= '0;
        cm_idx_q        <= '0;
        st_commit_q     <= 1'b0;
        st_commit_idx_q <= '0;
        bp_valid_q      <= 1'b0;
        bp_pc_q         <= '0;
        bp_taken_q      <= 1'b0;
        flush_q         <= 1'b0;
        flush_pc_q      <= '0;
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        for (int k = 0; k < WB_PORTS; k++) begin
          if (wb_valid[k]) ready_q[wb_idx[k*ROB_WIDTH +: ROB_WIDTH]] <= 1'b1;
        end
        if (issue_w) ready_q[tail_q] <= 1'b0;
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
          cm_valid_q[s]                      <= fire_w[s];
          cm_rd_q[s*5 +: 5]                  <= fire_w[s] ? rd_q[slot_idx_w[s]] : 5'd0;
          cm_val_q[s*32 +: 32]               <= fire_w[s] ? val_q[slot_idx_w[s]] : 32'd0;
          cm_idx_q[s*ROB_WIDTH +: ROB_WIDTH] <= fire_w[s] ? slot_idx_w[s] : '0;
        end
        st_commit_q     <= commit0_w && st_q[head_q];
        st_commit_idx_q <= (commit0_w && st_q[head_q]) ? head_q : '0;
        bp_valid_q      <= commit0_w && br_q[head_q];
        bp_pc_q         <= (commit0_w && br_q[head_q]) ? pc_q[head_q] : 32'd0;
        bp_taken_q      <= commit0_w && br_q[head_q] && taken_q[head_q];
        flush_q         <= mispred_w;
        flush_pc_q      <= !mispred_w ? 32'd0 :
                           (taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4);
      end
    end
  end

  // Entry payload: writeback results first, then a new issue claims its slot
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && !flush_q) begin
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k]) begin
          val_q[wb_idx[k*ROB_WIDTH +: ROB_WIDTH]]    <= wb_val[k*32 +: 32];
          taken_q[wb_idx[k*ROB_WIDTH +: ROB_WIDTH]]  <= wb_taken[k];
          target_q[wb_idx[k*ROB_WIDTH +: ROB_WIDTH]] <= wb_target[k*32 +: 32];
        end
      end
      if (issue_w) begin
        rd_q[tail_q]    <= issue_rd;
        pc_q[tail_q]    <= issue_pc;
        br_q[tail_q]    <= issue_is_br;
        jalr_q[tail_q]  <= issue_is_jalr;
        st_q[tail_q]    <= issue_is_store;
        pred_q[tail_q]  <= issue_pred_taken;
        taken_q[tail_q] <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
